// File: rtl/emu_74194.sv
// rtl/emu_74194.sv - behavioural emulator of a 74194 4-bit universal shift register
//
// Presents the pins of a 74194 to an external chip checker. All device pins are
// asynchronous to Clk: each input goes through SYNC_STAGES flops, and the device
// CLK pin is edge-detected in the Clk domain.
//
// Optional feature macro: EMU_STUCK_QD_EN (stuck-at-0 fault on Pin12 driven by FaultSel).
//
// Ports:
//   Clk       system clock, only clock in the block
//   Reset     asynchronous active-high reset
//   Run       emulation enable; low freezes Q and ignores device clock edges
//   Pin1      CLR_n (active-low clear)
//   Pin2      SR serial input (shift right)
//   Pin3..6   parallel data A, B, C, D
//   Pin7      SL serial input (shift left)
//   Pin9      S0 mode select
//   Pin10     S1 mode select
//   Pin11     device CLK
//   Pin15..12 QA, QB, QC, QD outputs
//   EdgeCnt   count of accepted device clock rising edges (wraps)
//   FaultSel  stuck-at-0 select for QD (only with EMU_STUCK_QD_EN)

module emu_74194 #(
  parameter int SYNC_STAGES = 2,  // must be >= 2
  parameter int CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Pin1,
  input  logic             Pin2,
  input  logic             Pin3,
  input  logic             Pin4,
  input  logic             Pin5,
  input  logic             Pin6,
  input  logic             Pin7,
  input  logic             Pin9,
  input  logic             Pin10,
  input  logic             Pin11,
  input  logic             FaultSel,
  output logic             Pin12,
  output logic             Pin13,
  output logic             Pin14,
  output logic             Pin15,
  output logic [CNT_W-1:0] EdgeCnt
);

  // Bit order of the synchronized pin vector
  localparam int B_CLR_N = 0;
  localparam int B_SR    = 1;
  localparam int B_A     = 2;
  localparam int B_B     = 3;
  localparam int B_C     = 4;
  localparam int B_D     = 5;
  localparam int B_SL    = 6;
  localparam int B_S0    = 7;
  localparam int B_S1    = 8;
  localparam int B_CLK   = 9;

  logic [9:0] pins_raw;
  logic [9:0] sync_r [SYNC_STAGES];
  logic [9:0] pins_s;

  logic       clk_d;
  logic       clk_rise;
  logic       accept;
  logic [1:0] mode;

  // q holds {QA, QB, QC, QD}
  logic [3:0]       q;
  logic [3:0]       q_next;
  logic [CNT_W-1:0] cnt;

  assign pins_raw = {Pin11, Pin10, Pin9, Pin7, Pin6, Pin5, Pin4, Pin3, Pin2, Pin1};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= pins_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign pins_s = sync_r[SYNC_STAGES-1];

  // clk_d tracks the synchronized CLK regardless of Run or clear, so a CLK that
  // is already high when Run rises or CLR_n releases never produces an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_d <= 1'b0;
    end else begin
      clk_d <= pins_s[B_CLK];
    end
  end

  assign clk_rise = pins_s[B_CLK] & ~clk_d;
  assign accept   = clk_rise & Run & pins_s[B_CLR_N];
  assign mode     = {pins_s[B_S1], pins_s[B_S0]};

  always_comb begin
    q_next = q;
    unique case (mode)
      2'b00: q_next = q;
      2'b01: q_next = {pins_s[B_SR], q[3:1]};
      2'b10: q_next = {q[2:0], pins_s[B_SL]};
      2'b11: q_next = {pins_s[B_A], pins_s[B_B], pins_s[B_C], pins_s[B_D]};
      default: q_next = q;
    endcase
  end

  // Clear outranks both the edge and Run; an edge coinciding with clear is not counted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q   <= 4'b0000;
      cnt <= '0;
    end else if (!pins_s[B_CLR_N]) begin
      q   <= 4'b0000;
    end else if (accept) begin
      q   <= q_next;
      cnt <= cnt + 1'b1;
    end
  end

  assign Pin15   = q[3];
  assign Pin14   = q[2];
  assign Pin13   = q[1];
  assign EdgeCnt = cnt;

`ifdef EMU_STUCK_QD_EN
  logic fault_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= FaultSel;
    end
  end

  // Fault masks only the pin; the internal register keeps shifting normally.
  assign Pin12 = q[0] & ~fault_q;
`else
  logic unused_fault_sel;

  assign unused_fault_sel = FaultSel;
  assign Pin12            = q[0];
`endif

endmodule

// File: tb/tb_emu_74194.sv
// tb/tb_emu_74194.sv - self-checking bench for emu_74194

module tb_emu_74194;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic       Pin1, Pin2, Pin3, Pin4, Pin5, Pin6, Pin7, Pin9, Pin10, Pin11;
  logic       FaultSel;
  logic       Pin12, Pin13, Pin14, Pin15;
  logic [7:0] EdgeCnt;

  int checks = 0;
  int errors = 0;

  // Reference model: Q as an integer 0..15 with QA as MSB, count modulo 256
  int mq   = 0;
  int mcnt = 0;

  emu_74194 #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run),
    .Pin1(Pin1), .Pin2(Pin2), .Pin3(Pin3), .Pin4(Pin4), .Pin5(Pin5), .Pin6(Pin6),
    .Pin7(Pin7), .Pin9(Pin9), .Pin10(Pin10), .Pin11(Pin11), .FaultSel(FaultSel),
    .Pin12(Pin12), .Pin13(Pin13), .Pin14(Pin14), .Pin15(Pin15), .EdgeCnt(EdgeCnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] q_obs();
    return {28'd0, Pin15, Pin14, Pin13, Pin12};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_mode(input int s1s0, input int abcd, input bit sr, input bit sl);
    {Pin10, Pin9} = s1s0[1:0];
    {Pin3, Pin4, Pin5, Pin6} = abcd[3:0];
    Pin2 = sr;
    Pin7 = sl;
  endtask

  // Apply one device-clock edge to the model using the 74194 truth table
  task automatic model_edge();
    int m;
    if (!Pin1) begin
      mq = 0;
    end else if (Run) begin
      m = {Pin10, Pin9};
      case (m)
        1: mq = (Pin2 * 8) + (mq / 2);
        2: mq = ((mq * 2) % 16) + Pin7;
        3: mq = {Pin3, Pin4, Pin5, Pin6};
        default: mq = mq;
      endcase
      mcnt = (mcnt + 1) % 256;
    end
  endtask

  // Setup time, CLK high 4 cycles, low 4 cycles
  task automatic pulse();
    cyc(2);
    Pin11 = 1'b1;
    model_edge();
    cyc(4);
    Pin11 = 1'b0;
    cyc(4);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_q"}, q_obs(), mq);
    check({tag, "_cnt"}, {24'd0, EdgeCnt}, mcnt);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b1; FaultSel = 1'b0;
    Pin1 = 1'b0; Pin2 = 1'b0; Pin3 = 1'b0; Pin4 = 1'b0; Pin5 = 1'b0; Pin6 = 1'b0;
    Pin7 = 1'b0; Pin9 = 1'b0; Pin10 = 1'b0; Pin11 = 1'b0;

    // Reset then idle
    cyc(3);
    check("reset_q", q_obs(), 0);
    check("reset_cnt", {24'd0, EdgeCnt}, 0);
    Reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      check("idle_q", q_obs(), 0);
      check("idle_cnt", {24'd0, EdgeCnt}, 0);
    end

    Pin1 = 1'b1;

    // Parallel load 1011 with latency check
    set_mode(3, 4'b1011, 1'b0, 1'b0);
    cyc(2);
    Pin11 = 1'b1;
    cyc(2);
    check("load_lat_q_old", q_obs(), 0);
    check("load_lat_cnt_old", {24'd0, EdgeCnt}, 0);
    model_edge();
    cyc(1);
    check("load_lat_q_new", q_obs(), 4'b1011);
    check("load_lat_cnt_new", {24'd0, EdgeCnt}, 1);
    cyc(1);
    Pin11 = 1'b0;
    cyc(4);
    check_model("load");

    // Shift right twice with SR=0
    set_mode(1, 0, 1'b0, 1'b0);
    pulse();
    pulse();
    check("shr_q", q_obs(), 4'b0010);
    check("shr_cnt", {24'd0, EdgeCnt}, 3);

    // Shift left with SL=1
    set_mode(2, 0, 1'b0, 1'b1);
    pulse();
    check("shl_q", q_obs(), 4'b0101);
    check("shl_cnt", {24'd0, EdgeCnt}, 4);

    // CLR_n fall coinciding with CLK rise: clear wins, no count
    cyc(2);
    Pin1 = 1'b0;
    Pin11 = 1'b1;
    mq = 0;
    cyc(4);
    Pin1 = 1'b1;  // CLK still high: releasing clear must not create an edge
    cyc(4);
    Pin11 = 1'b0;
    cyc(4);
    check("clr_q", q_obs(), 0);
    check("clr_cnt", {24'd0, EdgeCnt}, 4);
    check_model("clr");

    // Run gating
    set_mode(3, 4'b1110, 1'b1, 1'b1);
    Run = 1'b0;
    repeat (3) pulse();
    check("run0_q", q_obs(), 0);
    check("run0_cnt", {24'd0, EdgeCnt}, 4);

    // Run rising while CLK already high produces no edge
    cyc(2);
    Pin11 = 1'b1;
    cyc(4);
    Run = 1'b1;
    cyc(4);
    Pin11 = 1'b0;
    cyc(4);
    check("run_rise_q", q_obs(), 0);
    check("run_rise_cnt", {24'd0, EdgeCnt}, 4);

    // 256 hold-mode pulses wrap the counter back to 4
    set_mode(0, 4'b1111, 1'b1, 1'b1);
    repeat (256) pulse();
    check("wrap_q", q_obs(), 0);
    check("wrap_cnt", {24'd0, EdgeCnt}, 4);
    check_model("wrap");

    // Randomized operation against the model
    for (int i = 0; i < 40; i++) begin
      set_mode($urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom), 1'($urandom));
      Run = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) begin
        cyc(2);
        Pin1 = 1'b0;
        mq = 0;
        cyc(4);
        Pin1 = 1'b1;
        cyc(3);
      end else begin
        pulse();
      end
      check_model("rand");
    end
    Run = 1'b1;

    // Stuck-at feature: load 1111 first
    set_mode(3, 4'b1111, 1'b0, 1'b0);
    pulse();
    check("ld1111_q", q_obs(), 4'b1111);
    FaultSel = 1'b1;
    cyc(1);
`ifdef EMU_STUCK_QD_EN
    check("fault_qd", {31'd0, Pin12}, 0);
    check("fault_others", {29'd0, Pin15, Pin14, Pin13}, 3'b111);
    FaultSel = 1'b0;
    cyc(1);
    check("fault_off_qd", {31'd0, Pin12}, 1);
`else
    check("nofault_qd", {31'd0, Pin12}, 1);
    check("nofault_others", {29'd0, Pin15, Pin14, Pin13}, 3'b111);
    FaultSel = 1'b0;
`endif

    // CLK already high at reset release yields exactly one edge
    set_mode(0, 0, 1'b0, 1'b0);
    cyc(2);
    Reset = 1'b1;
    Pin11 = 1'b1;
    mq = 0;
    mcnt = 0;
    cyc(2);
    check("rst_hi_q", q_obs(), 0);
    check("rst_hi_cnt", {24'd0, EdgeCnt}, 0);
    Reset = 1'b0;
    model_edge();
    cyc(6);
    check_model("rst_hi_edge");
    Pin11 = 1'b0;
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
